// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time byte-stream loader that assembles little-endian words
// into the instruction RAM from BASE_ADDR upward while holding the CPU in reset.
module instr_mem_loader #(
    parameter int A_WIDTH = 32,
    parameter logic [A_WIDTH-1:0] BASE_ADDR = 32'hBFC00000,
    parameter int LEN_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE} state_t;
    state_t state, state_n;
    logic [7:0] len_lo;
    logic [LEN_WIDTH-1:0] remaining, len_rx;
    logic [1:0] idx;
    logic [31:0] shift, csum, word;
    logic [A_WIDTH-1:0] addr;
    logic hs;
    assign in_ready = state inside {LEN0, LEN1, DATA, CSUM};
    assign hs = in_valid & in_ready;
    assign word = {in_data, shift[31:8]};
    assign len_rx = LEN_WIDTH'({in_data, len_lo});
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LEN0 : IDLE;
            LEN0:    state_n = hs ? LEN1 : LEN0;
            LEN1:    state_n = hs ? ((len_rx == '0) ? CSUM : DATA) : LEN1;
            DATA:    state_n = (hs && idx == 2'd3) ? WRITE : DATA;
            WRITE:   state_n = (remaining == LEN_WIDTH'(1)) ? CSUM : DATA;
            CSUM:    state_n = (hs && idx == 2'd3) ? DONE : CSUM;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_lo    <= '0;
            remaining <= '0;
            idx       <= '0;
            shift     <= '0;
            csum      <= '0;
            addr      <= BASE_ADDR;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_n;
            mem_we <= state_n == WRITE;
            done   <= state_n == DONE;
            if (state == IDLE && start) begin
                addr     <= BASE_ADDR;
                csum     <= '0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end
            if (state_n == DONE) cpu_hold <= 1'b0;
            if (hs) begin
                shift <= word;
                idx   <= idx + 2'd1;
            end
            if (state == LEN0 && hs) len_lo <= in_data;
            // byte index restarts once the header is complete, then wraps every 4 bytes
            if (state == LEN1 && hs) begin
                remaining <= len_rx;
                idx       <= '0;
            end
            if (state == DATA && hs && idx == 2'd3) begin
                mem_addr  <= addr;
                mem_wdata <= word;
            end
            if (state == WRITE) begin
                csum      <= csum ^ mem_wdata;
                addr      <= addr + A_WIDTH'(4);
                remaining <= remaining - LEN_WIDTH'(1);
            end
            if (state == CSUM && hs && idx == 2'd3) err <= word != csum;
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized frame loads checked against a
// frame-level reference model (expected write list, XOR checksum, done/hold behaviour).
module tb_instr_mem_loader;
    localparam logic [31:0] BASE = 32'hBFC00000;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, mem_we, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;
    int checks = 0, errors = 0;
    logic [31:0] wr_addr[$], wr_data[$];
    int done_cnt = 0, we_ready_bad = 0;
    logic hold_at_done = 1'b0, hold_before = 1'b0, prev_hold = 1'b0;
    logic [31:0] prog[$];

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (in_ready) we_ready_bad++;
        end
        if (done) begin
            done_cnt++;
            hold_at_done = cpu_hold;
            hold_before  = prev_hold;
        end
        prev_hold = cpu_hold;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int gap, input int start_at);
        for (int i = 0; i < b.size(); i++) begin
            int g, t;
            g = gap > 0 ? int'($urandom_range(0, gap)) : 0;
            repeat (g) begin
                @(negedge clk);
                in_valid = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data = b[i];
            start = (i == start_at);
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                start = 1'b0;
                t++;
            end
            if (t >= 100) chk("byte_accept_timeout", 32'(t), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [31:0] w[$], input logic zero_csum,
                            input int gap, input int start_at);
        logic [7:0] b[$];
        logic [31:0] x, rx;
        int n, w0, d0, t;
        n = w.size();
        x = 32'h0;
        b.push_back(8'(n));
        b.push_back(8'(n >> 8));
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) b.push_back(8'(w[i] >> (8 * k)));
            x ^= w[i];
        end
        rx = zero_csum ? 32'h0 : x;
        for (int k = 0; k < 4; k++) b.push_back(8'(rx >> (8 * k)));
        w0 = wr_addr.size();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_hold_on_start"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_err_cleared"}, 32'(err), 32'd0);
        send_bytes(b, gap, start_at);
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_write_count"}, 32'(wr_addr.size() - w0), 32'(n));
        for (int i = 0; i < n && w0 + i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, wr_addr[w0 + i], BASE + 32'(4 * i));
            chk({tag, "_data"}, wr_data[w0 + i], w[i]);
        end
        chk({tag, "_hold_before_done"}, 32'(hold_before), 32'd1);
        chk({tag, "_hold_at_done"}, 32'(hold_at_done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(rx != x));
        chk({tag, "_ready_in_write"}, 32'(we_ready_bad), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_err_held"}, 32'(err), 32'(rx != x));
        chk({tag, "_hold_idle"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        logic [7:0] part[$];
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        prog = {32'h00500013, 32'h00100093};
        run_load("load2", prog, 1'b0, 0, -1);
        run_load("badcsum", prog, 1'b1, 0, -1);
        prog = {};
        run_load("empty", prog, 1'b0, 0, -1);
        prog = {32'h00500013, 32'h00100093};
        run_load("gaps", prog, 1'b0, 3, 5);
        // abort after 6 payload bytes: one word has been written, second is partial
        part = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
        w0 = wr_addr.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_bytes(part, 0, -1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_writes", 32'(wr_addr.size() - w0), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_mem_addr", mem_addr, BASE);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_load("after_rst", prog, 1'b0, 0, -1);
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 5));
            prog = {};
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            run_load("rand", prog, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 8)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
